// File: rtl/nn_io_pkg.sv
// Shared types and helpers for the network stream I/O controller.
package nn_io_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Address width that never collapses to zero bits for a depth of one.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nn_buf_1r1w.sv
// One-write / one-registered-read buffer. Storage is not reset; only the read register is.
// A read of the address being written in the same cycle returns the new data.
module nn_buf_1r1w #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 8,
   parameter int AW     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   // Sized to the full address space so any address indexes cleanly; writes past DEPTH are dropped.
   logic [DATA_W-1:0] mem_q [2**AW];
   logic [DATA_W-1:0] rdata_q;
   logic              wr_ok;

   assign wr_ok   = we_i && (int'(waddr_i) < DEPTH);
   assign rdata_o = rdata_q;

   // Storage write.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read with write-through forwarding.
   always_ff @(posedge clk) begin
      if (rst)                                rdata_q <= '0;
      else if (re_i && wr_ok && waddr_i == raddr_i) rdata_q <= wdata_i;
      else if (re_i)                          rdata_q <= mem_q[raddr_i];
   end

endmodule

// File: rtl/nn_stream_io_ctrl.sv
// Fill / run / drain sequencer around a layered network core: gathers an input vector,
// hands it to the core with a level req/ack, then streams the result vector out.
module nn_stream_io_ctrl
   import nn_io_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_IN   = 2,
   parameter int N_OUT  = 1,
   parameter int IA_W   = clog2_min1(N_IN),
   parameter int OA_W   = clog2_min1(N_OUT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid_i,
   input  logic signed [DATA_W-1:0] in_data_i,
   output logic                     in_ready_o,
   input  logic [IA_W-1:0]          ib_raddr_i,
   output logic signed [DATA_W-1:0] ib_rdata_o,
   output logic                     net_req_o,
   input  logic                     net_ack_i,
   input  logic                     res_we_i,
   input  logic [OA_W-1:0]          res_waddr_i,
   input  logic signed [DATA_W-1:0] res_wdata_i,
   output logic                     out_valid_o,
   output logic signed [DATA_W-1:0] out_data_o,
   output logic                     out_last_o,
   input  logic                     out_ready_i,
   output logic                     busy_o,
   output logic                     err_o,
   output logic [15:0]              n_done_o
);

   localparam logic [IA_W-1:0] WR_LAST = IA_W'(N_IN - 1);
   localparam logic [OA_W-1:0] RD_LAST = OA_W'(N_OUT - 1);

   state_e            state_q, state_d;
   logic [IA_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [OA_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic              err_q, err_d;
   logic [15:0]       n_done_q, n_done_d;
   logic              in_fire, out_fire, rb_we, rb_re, res_in_range;

   assign in_fire      = in_valid_i && in_ready_o;
   assign out_fire     = out_valid_o && out_ready_i;
   assign res_in_range = int'(res_waddr_i) < N_OUT;
   assign rb_we        = res_we_i && (state_q == ST_RUN) && res_in_range;
   // Result buffer is read only toward DRAIN so out_data holds its last word otherwise.
   assign rb_re        = (state_d == ST_DRAIN);
   assign err_o        = err_q;
   assign n_done_o     = n_done_q;

   nn_buf_1r1w #(.DEPTH(N_IN), .DATA_W(DATA_W), .AW(IA_W)) u_ibuf (
      .clk     (clk),
      .rst     (rst),
      .we_i    (in_fire),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data_i),
      .re_i    (1'b1),
      .raddr_i (ib_raddr_i),
      .rdata_o (ib_rdata_o)
   );

   // Read address runs one step ahead so out_data tracks rd_ptr_q with no bubble.
   nn_buf_1r1w #(.DEPTH(N_OUT), .DATA_W(DATA_W), .AW(OA_W)) u_rbuf (
      .clk     (clk),
      .rst     (rst),
      .we_i    (rb_we),
      .waddr_i (res_waddr_i),
      .wdata_i (res_wdata_i),
      .re_i    (rb_re),
      .raddr_i (rd_ptr_d),
      .rdata_o (out_data_o)
   );

   // State, pointers and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FILL;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
         n_done_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
         n_done_q <= n_done_d;
      end
   end

   // Next-state: sequence the vector through fill, core run and drain.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      n_done_d = n_done_q;
      err_d    = err_q;
      unique case (state_q)
         ST_FILL: if (in_fire) begin
            if (wr_ptr_q == WR_LAST) begin
               wr_ptr_d = '0;
               state_d  = ST_RUN;
            end else begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
         ST_RUN: if (net_ack_i) state_d = ST_DRAIN;
         ST_DRAIN: if (out_fire) begin
            if (rd_ptr_q == RD_LAST) begin
               rd_ptr_d = '0;
               n_done_d = n_done_q + 16'd1;
               state_d  = ST_FILL;
            end else begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
         end
         default: state_d = ST_FILL;
      endcase
      // Core writes outside RUN, out-of-range writes and stray acks are protocol errors.
      if (res_we_i && ((state_q != ST_RUN) || !res_in_range)) err_d = 1'b1;
      if (net_ack_i && (state_q != ST_RUN))                   err_d = 1'b1;
   end

   // Outputs decoded from the registered state.
   always_comb begin
      in_ready_o  = !rst && (state_q == ST_FILL);
      net_req_o   = (state_q == ST_RUN);
      out_valid_o = (state_q == ST_DRAIN);
      out_last_o  = (state_q == ST_DRAIN) && (rd_ptr_q == RD_LAST);
      busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   end

endmodule

// File: tb/tb_nn_stream_io_ctrl.sv
// Bench for nn_stream_io_ctrl (N_IN=4, N_OUT=3) with a behavioural core and an output scoreboard.
module tb_nn_stream_io_ctrl;

   localparam int N_IN  = 4;
   localparam int N_OUT = 3;

   typedef struct {
      logic signed [7:0] d;
      logic              l;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic signed [7:0] in_data = '0;
   logic              in_ready_o;
   logic [1:0]        ib_raddr = '0;
   logic signed [7:0] ib_rdata_o;
   logic              net_req_o;
   logic              net_ack;
   logic              ack_en = 1'b0;
   logic              res_we = 1'b0;
   logic [1:0]        res_waddr = '0;
   logic signed [7:0] res_wdata = '0;
   logic              out_valid_o, out_last_o, busy_o, err_o;
   logic              out_ready = 1'b0;
   logic signed [7:0] out_data_o;
   logic [15:0]       n_done_o;

   exp_t              exp_out[$];
   logic signed [7:0] exp_in[$];
   int                n_chk = 0, n_fail = 0;
   int                exp_done = 0, done_base = 0;
   int                fb_req = 0, fb_done = 0;
   bit                skip0 = 0, bad_run = 0, tgl_mode = 0, chk_gap = 0, chk_inr = 0;
   logic signed [7:0] prev0 = '0;

   always #5 clk = ~clk;

   // Core drops ack as soon as req falls.
   assign net_ack = ack_en & net_req_o;

   nn_stream_io_ctrl #(.DATA_W(8), .N_IN(N_IN), .N_OUT(N_OUT)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready_o),
      .ib_raddr_i  (ib_raddr),
      .ib_rdata_o  (ib_rdata_o),
      .net_req_o   (net_req_o),
      .net_ack_i   (net_ack),
      .res_we_i    (res_we),
      .res_waddr_i (res_waddr),
      .res_wdata_i (res_wdata),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_ready_i (out_ready),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .n_done_o    (n_done_o)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   // Core model: reads the input buffer, writes res[k]=in[k]+in[k+1], acks with the last write.
   initial begin : core
      logic signed [7:0] rd [N_IN];
      forever begin
         @(negedge clk);
         if (fb_req != fb_done) begin
            res_we = 1'b1; res_waddr = 2'd0; res_wdata = 8'sh55;
            @(negedge clk);
            res_we  = 1'b0;
            fb_done = fb_req;
         end else if (net_req_o) begin
            for (int i = 0; i < N_IN; i++) begin
               ib_raddr = 2'(i);
               @(negedge clk);
               rd[i] = ib_rdata_o;
               if (exp_in.size() > 0) chk("ibuf_rd", ib_rdata_o, exp_in.pop_front());
               else                   chk("ibuf_rd_unexp", exp_in.size(), 1);
            end
            if (bad_run) begin
               res_we = 1'b1; res_waddr = 2'd3; res_wdata = 8'sh7f;
               @(negedge clk);
            end
            for (int k = 0; k < N_OUT; k++) begin
               res_we    = !(skip0 && k == 0);
               res_waddr = 2'(k);
               res_wdata = rd[k] + rd[k+1];
               if (k == N_OUT - 1) ack_en = 1'b1;
               @(negedge clk);
            end
            res_we = 1'b0;
            ack_en = 1'b0;
         end
      end
   end

   // Output side: drives out_ready and checks every valid word against the scoreboard front.
   always @(negedge clk) begin
      exp_t e;
      out_ready = tgl_mode ? ~out_ready : 1'b1;
      if (chk_gap) begin
         chk("gapless", out_valid_o, 1);
         chk_gap = 0;
      end
      if (chk_inr) begin
         chk("in_ready_ret", in_ready_o, 1);
         chk("n_done", n_done_o, (exp_done - done_base) & 32'hFFFF);
         chk_inr = 0;
      end
      if (out_valid_o && !rst) begin
         if (exp_out.size() == 0) chk("out_unexp", out_valid_o, 0);
         else begin
            e = exp_out[0];
            chk("out_data", out_data_o, e.d);
            chk("out_last", out_last_o, e.l);
            if (out_ready) begin
               void'(exp_out.pop_front());
               if (e.l) begin
                  exp_done++;
                  chk_inr = 1;
               end else if (!tgl_mode) chk_gap = 1;
            end
         end
      end
   end

   // Stream one vector (word0 in the low byte); gap inserts an idle cycle between words.
   task automatic send_vec(input logic [31:0] pv, input bit gap);
      logic signed [7:0] v [N_IN];
      exp_t e;
      int   to;
      for (int i = 0; i < N_IN; i++) v[i] = pv[8*i +: 8];
      for (int i = 0; i < N_IN; i++) begin
         if (gap && i > 0) @(negedge clk);
         in_valid = 1'b1;
         in_data  = v[i];
         to = 0;
         while (!in_ready_o && to < 400) begin
            @(negedge clk);
            to++;
         end
         if (to >= 400) chk("in_ready_to", in_ready_o, 1);
         @(negedge clk);
         in_valid = 1'b0;
      end
      for (int i = 0; i < N_IN; i++) exp_in.push_back(v[i]);
      chk("net_req_rise", net_req_o, 1);
      chk("in_ready_fall", in_ready_o, 0);
      chk("busy_run", busy_o, 1);
      for (int k = 0; k < N_OUT; k++) begin
         e.d = (skip0 && k == 0) ? prev0 : v[k] + v[k+1];
         e.l = (k == N_OUT - 1);
         if (k == 0) prev0 = e.d;
         exp_out.push_back(e);
      end
   endtask

   task automatic wait_done(input int target);
      int to = 0;
      while ((exp_done < target || exp_out.size() != 0) && to < 1000) begin
         @(negedge clk);
         to++;
      end
      if (to >= 1000) chk("drain_to", exp_done, target);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_net_req", net_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_n_done", n_done_o, 0);
      @(negedge clk);
      rst = 1'b0;
      done_base = exp_done;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready_o, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_in_ready", in_ready_o, 0);
      chk("reset_net_req", net_req_o, 0);
      chk("reset_out_valid", out_valid_o, 0);
      chk("reset_out_last", out_last_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_err", err_o, 0);
      chk("reset_n_done", n_done_o, 0);
      chk("reset_ib_rdata", ib_rdata_o, 0);
      chk("reset_out_data", out_data_o, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready_o, 1);
      chk("idle_busy", busy_o, 0);

      // Basic inference: 5,-3,1,2 -> 2,-2,3.
      send_vec(32'h02_01_FD_05, 1'b0);
      wait_done(1);
      chk("err_clean", err_o, 0);

      // Gapped input stream.
      send_vec(32'h80_7F_10_F0, 1'b1);
      wait_done(2);

      // Output backpressure toggling.
      tgl_mode = 1;
      send_vec(32'h11_22_33_44, 1'b0);
      wait_done(3);
      tgl_mode = 0;
      chk("err_clean2", err_o, 0);

      // Write in FILL, then a run that skips rbuf[0] and writes out of range.
      fb_req++;
      repeat (3) @(negedge clk);
      chk("err_fill_we", err_o, 1);
      skip0 = 1; bad_run = 1;
      send_vec(32'h01_02_03_04, 1'b0);
      wait_done(4);
      skip0 = 0; bad_run = 0;
      send_vec(32'h05_06_07_08, 1'b0);
      wait_done(5);
      chk("err_sticky", err_o, 1);

      // Reset after one of four words; only the following vector counts.
      in_valid = 1'b1; in_data = 8'sh09;
      @(negedge clk);
      in_valid = 1'b0;
      do_reset();
      send_vec(32'hFF_FE_FD_FC, 1'b0);
      wait_done(6);
      chk("n_done_after_rst", n_done_o, 1);

      // Three back-to-back inferences from a fresh reset.
      do_reset();
      send_vec(32'h0A_0B_0C_0D, 1'b0);
      send_vec(32'hF1_E2_D3_C4, 1'b0);
      send_vec(32'h40_C0_20_E0, 1'b0);
      wait_done(9);
      chk("n_done_b2b", n_done_o, 3);
      chk("err_b2b", err_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
